bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of a single peripheral bus.
//
// Ports:
//   clk_clk, reset_reset          clock and synchronous active-high reset
//   mN_address/bus_enable/byte_enable/rw/write_data   request from master N (N = 0,1)
//   mN_acknowledge, mN_read_data  registered one-cycle completion and read data to master N
//   s_address/bus_enable/byte_enable/rw/write_data    registered bus to the peripheral
//   s_acknowledge, s_read_data    peripheral completion and read data
//   timeout_error                 sticky flag, set when a transaction times out
//
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to enable the slave-wait timeout.
// A timed-out transaction completes with all-ones read data. Without the macro, BUSY
// waits indefinitely for s_acknowledge and timeout_error is tied to 0.

module bus_arbiter #(
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_bus_enable,
  input  logic [DATA_W/8-1:0]   m0_byte_enable,
  input  logic                  m0_rw,
  input  logic [DATA_W-1:0]     m0_write_data,
  output logic                  m0_acknowledge,
  output logic [DATA_W-1:0]     m0_read_data,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_bus_enable,
  input  logic [DATA_W/8-1:0]   m1_byte_enable,
  input  logic                  m1_rw,
  input  logic [DATA_W-1:0]     m1_write_data,
  output logic                  m1_acknowledge,
  output logic [DATA_W-1:0]     m1_read_data,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_bus_enable,
  output logic [DATA_W/8-1:0]   s_byte_enable,
  output logic                  s_rw,
  output logic [DATA_W-1:0]     s_write_data,
  input  logic                  s_acknowledge,
  input  logic [DATA_W-1:0]     s_read_data,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t              state, state_d;
  logic                last_grant;   // master granted most recently
  logic                grant;        // master owning the current transaction
  logic                winner_c;
  logic                take_c;       // latch a new request this cycle
  logic                done_c;       // complete the current transaction this cycle
  logic [DATA_W-1:0]   rdata_c;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0]    cnt;
  logic                tmo_fire_c;
`endif

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_d;
  end

  // Next state, arbitration and transaction strobes
  always_comb begin
    state_d  = state;
    take_c   = 1'b0;
    done_c   = 1'b0;
    rdata_c  = s_read_data;
`ifdef BUS_ARBITER_TIMEOUT_EN
    tmo_fire_c = 1'b0;
`endif
    // A tie goes to the master not granted last; a lone requester always wins.
    if (m0_bus_enable && m1_bus_enable) winner_c = ~last_grant;
    else                                winner_c = m1_bus_enable;

    case (state)
      IDLE: begin
        if (m0_bus_enable || m1_bus_enable) begin
          take_c  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_acknowledge) begin
          done_c  = 1'b1;
          state_d = RELEASE;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        // The peripheral acknowledge takes priority over an expiring counter.
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_c     = 1'b1;
          tmo_fire_c = 1'b1;
          state_d    = RELEASE;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BUS_ARBITER_TIMEOUT_EN
    if (tmo_fire_c) rdata_c = '1;
`endif
  end

  // Peripheral bus, grant tracking and master responses
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      s_address      <= '0;
      s_bus_enable   <= 1'b0;
      s_byte_enable  <= '0;
      s_rw           <= 1'b0;
      s_write_data   <= '0;
      m0_acknowledge <= 1'b0;
      m1_acknowledge <= 1'b0;
      m0_read_data   <= '0;
      m1_read_data   <= '0;
    end else begin
      m0_acknowledge <= 1'b0;
      m1_acknowledge <= 1'b0;
      if (take_c) begin
        grant        <= winner_c;
        last_grant   <= winner_c;
        s_bus_enable <= 1'b1;
        if (winner_c) begin
          s_address     <= m1_address;
          s_byte_enable <= m1_byte_enable;
          s_rw          <= m1_rw;
          s_write_data  <= m1_write_data;
        end else begin
          s_address     <= m0_address;
          s_byte_enable <= m0_byte_enable;
          s_rw          <= m0_rw;
          s_write_data  <= m0_write_data;
        end
      end
      if (done_c) begin
        s_bus_enable <= 1'b0;
        // Read data only updates for reads; writes leave it untouched.
        if (grant) begin
          m1_acknowledge <= 1'b1;
          if (s_rw) m1_read_data <= rdata_c;
        end else begin
          m0_acknowledge <= 1'b1;
          if (s_rw) m0_read_data <= rdata_c;
        end
      end
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  // Slave-wait counter and sticky timeout flag
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt           <= '0;
      timeout_error <= 1'b0;
    end else begin
      if (take_c)             cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 1'b1;
      if (tmo_fire_c) timeout_error <= 1'b1;
    end
  end
`else
  assign timeout_error = 1'b0;
`endif

endmodule
